// File: rtl/adder_measure_seq.sv
// Measurement sequencer for the ring-oscillator adder: load, settle, run, drain.
// Define ADDER_SEQ_SAT_EN for a saturating edge counter (default wraps).
module adder_measure_seq #(
   parameter int COUNT_W       = 24,
   parameter int WINDOW_W      = 16,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [31:0]         op_a,
   input  logic [31:0]         op_b,
   input  logic [4:0]          ring_sel,
   input  logic [4:0]          tap_sel,
   input  logic [WINDOW_W-1:0] window,
   input  logic                chain_out,
   output logic [31:0]         a_input,
   output logic [31:0]         b_input,
   output logic [31:0]         a_input_ring_bit_b,
   output logic [31:0]         s_output_bit_b,
   output logic                ring_en,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  count,
   output logic                overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_RUN,
      S_STOP,
      S_DONE
   } state_e;

   localparam logic [WINDOW_W-1:0] SETTLE_LAST =
      WINDOW_W'(SETTLE_CYCLES - 1);

   state_e              state_q, state_d;
   logic                start_q;
   logic [31:0]         a_q, b_q;
   logic [4:0]          ring_q, tap_q;
   logic [WINDOW_W-1:0] win_q;
   logic [WINDOW_W-1:0] tmr_q, tmr_d;
   logic [2:0]          sync_q;
   logic [COUNT_W-1:0]  count_q;
   logic                ovf_q;

   logic start_edge;
   logic load;
   logic abort_clr;
   logic rise;
   logic inc;

   assign start_edge = start & ~start_q;
   assign abort_clr  = abort & (state_q != S_IDLE);
   assign rise       = sync_q[1] & ~sync_q[2];
   assign inc        = rise & ((state_q == S_RUN) | (state_q == S_STOP));

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      load    = 1'b0;
      if (abort_clr) begin
         state_d = S_IDLE;
         tmr_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start_edge) begin
                  state_d = S_LOAD;
                  tmr_d   = '0;
                  load    = 1'b1;
               end
            end
            S_LOAD: begin
               state_d = S_SETTLE;
               tmr_d   = '0;
            end
            S_SETTLE: begin
               if (tmr_q == SETTLE_LAST) begin
                  state_d = S_RUN;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            S_RUN: begin
               if (tmr_q == win_q - 1'b1) begin
                  state_d = S_STOP;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            S_STOP: begin
               // Two drain cycles cover the synchronizer latency.
               if (tmr_q[0]) begin
                  state_d = S_DONE;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         start_q <= 1'b0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         start_q <= start;
         sync_q  <= {sync_q[1:0], chain_out};
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         ring_q <= '0;
         tap_q  <= '0;
         win_q  <= WINDOW_W'(1);
      end else if (load) begin
         a_q    <= op_a;
         b_q    <= op_b;
         ring_q <= ring_sel;
         tap_q  <= tap_sel;
         win_q  <= (window == '0) ? WINDOW_W'(1) : window;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (load || abort_clr) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (inc) begin
         if (&count_q) begin
            ovf_q <= 1'b1;
`ifdef ADDER_SEQ_SAT_EN
            count_q <= count_q;
`else
            count_q <= '0;
`endif
         end else begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   assign a_input  = a_q;
   assign b_input  = b_q;
   assign ring_en  = (state_q == S_RUN);
   assign busy     = (state_q == S_LOAD) | (state_q == S_SETTLE) |
                     (state_q == S_RUN)  | (state_q == S_STOP);
   assign done     = (state_q == S_DONE);
   assign count    = count_q;
   assign overflow = ovf_q;

   // Idle leaves the ring open and no sum bit tapped.
   assign a_input_ring_bit_b =
      (state_q == S_IDLE) ? '1 : ~(32'd1 << ring_q);
   assign s_output_bit_b =
      (state_q == S_IDLE) ? '1 : ~(32'd1 << tap_q);

endmodule

// File: tb/tb_adder_measure_seq.sv
// Testbench for adder_measure_seq: directed and random measurements
// against a schedule/edge-count model, with a 24-bit and a 4-bit counter.
module tb_adder_measure_seq;

   localparam int SETTLE = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [4:0]  ring_sel = '0;
   logic [4:0]  tap_sel = '0;
   logic [15:0] window = '0;
   logic        chain = 1'b0;

   logic [31:0] a_input, b_input, ring_m, tap_m;
   logic        ring_en, busy, done, ovf;
   logic [23:0] count;

   logic [31:0] a4, b4, ring_m4, tap_m4;
   logic        ring_en4, busy4, done4, ovf4;
   logic [3:0]  count4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   adder_measure_seq #(
      .COUNT_W(24), .WINDOW_W(16), .SETTLE_CYCLES(SETTLE)
   ) u_dut (
      .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .abort(abort),
      .op_a(op_a), .op_b(op_b), .ring_sel(ring_sel), .tap_sel(tap_sel),
      .window(window), .chain_out(chain),
      .a_input(a_input), .b_input(b_input),
      .a_input_ring_bit_b(ring_m), .s_output_bit_b(tap_m),
      .ring_en(ring_en), .busy(busy), .done(done),
      .count(count), .overflow(ovf)
   );

   adder_measure_seq #(
      .COUNT_W(4), .WINDOW_W(16), .SETTLE_CYCLES(SETTLE)
   ) u_dut4 (
      .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .abort(abort),
      .op_a(op_a), .op_b(op_b), .ring_sel(ring_sel), .tap_sel(tap_sel),
      .window(window), .chain_out(chain),
      .a_input(a4), .b_input(b4),
      .a_input_ring_bit_b(ring_m4), .s_output_bit_b(tap_m4),
      .ring_en(ring_en4), .busy(busy4), .done(done4),
      .count(count4), .overflow(ovf4)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk1({tag, ".ring_en"}, ring_en, 1'b0);
      chk1({tag, ".busy"}, busy, 1'b0);
      chk1({tag, ".done"}, done, 1'b0);
      chkv({tag, ".count"}, 32'(count), 32'd0);
      chk1({tag, ".ovf"}, ovf, 1'b0);
      chkv({tag, ".ring_m"}, ring_m, 32'hFFFF_FFFF);
      chkv({tag, ".tap_m"}, tap_m, 32'hFFFF_FFFF);
   endtask

   // One full measurement from a start edge to one cycle into DONE.
   task automatic measure(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rs, input logic [4:0] ts,
                          input logic [15:0] w);
      int weff, last, rises, mx;
      logic exp_ring;
      logic [31:0] am, tm, e4;
      logic eo4;
      weff  = (w == 16'd0) ? 1 : int'(w);
      last  = SETTLE + weff + 4;
      rises = 0;
      am    = ~(32'd1 << rs);
      tm    = ~(32'd1 << ts);
      @(negedge clk);
      op_a = a; op_b = b; ring_sel = rs; tap_sel = ts; window = w;
      start = 1'b1;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         exp_ring = (k >= SETTLE + 2) && (k <= SETTLE + weff + 1);
         chk1("busy", busy, k <= SETTLE + weff + 3);
         chk1("done", done, k >= last);
         chk1("ring_en", ring_en, exp_ring);
         chkv("a_input", a_input, a);
         chkv("b_input", b_input, b);
         chkv("ring_mask", ring_m, am);
         chkv("tap_mask", tap_m, tm);
         if (exp_ring && ((k - SETTLE - 2) % 2 == 0)) begin
            chain = ~chain;
            if (chain) rises++;
         end
      end
      op_a = ~a; op_b = ~b; ring_sel = rs + 5'd1; window = 16'd0;
      @(negedge clk);
      chk1("done_hold", done, 1'b1);
      chkv("a_hold", a_input, a);
      chkv("mask_hold", ring_m, am);
      chkv("count24", 32'(count), 32'(rises));
      chk1("ovf24", ovf, 1'b0);
      mx = 15;
`ifdef ADDER_SEQ_SAT_EN
      e4  = (rises > mx) ? 32'(mx) : 32'(rises);
      eo4 = rises > mx;
`else
      e4  = 32'(rises % (mx + 1));
      eo4 = rises > mx;
`endif
      chkv("count4", 32'(count4), e4);
      chk1("ovf4", ovf4, eo4);
   endtask

   initial begin
      // Reset with the ring output toggling.
      repeat (4) begin
         @(negedge clk);
         chain = ~chain;
      end
      chk_idle("reset");
      chkv("reset.a", a_input, 32'd0);
      chkv("reset.b", b_input, 32'd0);
      chkv("reset.count4", 32'(count4), 32'd0);
      chain = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk_idle("post_reset");

      measure(32'h0000_FFFF, 32'd1, 5'd0, 5'd16, 16'd16);
      measure(32'h1234_5678, 32'h9ABC_DEF0, 5'd31, 5'd3, 16'd0);
      measure(32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd7, 5'd9, 16'd64);

      // Abort in the third RUN cycle, with a simultaneous start edge.
      @(negedge clk);
      op_a = 32'hA5A5_0001; op_b = 32'h5A5A_0002;
      ring_sel = 5'd4; tap_sel = 5'd5; window = 16'd10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (SETTLE + 3) @(negedge clk);
      chk1("abort.pre_ring", ring_en, 1'b1);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk_idle("abort");
      chkv("abort.a_hold", a_input, 32'hA5A5_0001);
      abort = 1'b0;
      @(negedge clk);
      chk1("abort.no_restart", busy, 1'b0);
      chk1("abort.done_low", done, 1'b0);
      start = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         measure($urandom, $urandom, 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 16'($urandom_range(0, 12)));
      end

      // Reset asserted in the middle of RUN.
      @(negedge clk);
      op_a = 32'h0F0F_0F0F; window = 16'd8; ring_sel = 5'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (SETTLE + 2) @(negedge clk);
      chk1("rstrun.pre_ring", ring_en, 1'b1);
      chain = ~chain;
      rst_n = 1'b0;
      #1;
      chk_idle("rstrun");
      chkv("rstrun.a", a_input, 32'd0);
      chain = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      measure(32'h0000_0001, 32'hFFFF_FFFF, 5'd1, 5'd30, 16'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
